multicycle_control: RTL

Multi-cycle control FSM that sequences the shared-ALU, shared-memory variant of the MIPS datapath over 3–5 clocks per instruction. It decodes the 6-bit opcode of the instruction register and drives every mux select and write strobe of that datapath. It stretches memory states on a `mem_ready` wait handshake, flags illegal opcodes, and counts retired instructions. It sits beside the datapath top level and replaces the single-cycle combinational `Controle` decode.

---
 rtl/multicycle_control.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multi-cycle control FSM for the shared-ALU / shared-memory
//                MIPS datapath. Decodes the opcode, drives all mux selects
//                and write strobes, stretches memory states on mem_ready,
//                flags illegal opcodes and counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [3:0]       ALUOp,
    output logic             selectRa,
    output logic             extendType,
    output logic             bneSelect,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    localparam logic [3:0] c_st_fetch   = 4'd0;
    localparam logic [3:0] c_st_decode  = 4'd1;
    localparam logic [3:0] c_st_memaddr = 4'd2;
    localparam logic [3:0] c_st_memrd   = 4'd3;
    localparam logic [3:0] c_st_memwb   = 4'd4;
    localparam logic [3:0] c_st_memwr   = 4'd5;
    localparam logic [3:0] c_st_exec    = 4'd6;
    localparam logic [3:0] c_st_rcomp   = 4'd7;
    localparam logic [3:0] c_st_branch  = 4'd8;
    localparam logic [3:0] c_st_jump    = 4'd9;
    localparam logic [3:0] c_st_iexec   = 4'd10;
    localparam logic [3:0] c_st_icomp   = 4'd11;
    localparam logic [3:0] c_st_jal     = 4'd12;
    localparam logic [3:0] c_st_error   = 4'd13;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_slti  = 6'b001010;

    localparam logic [3:0] c_alu_add   = 4'b0000;
    localparam logic [3:0] c_alu_sub   = 4'b0001;
    localparam logic [3:0] c_alu_funct = 4'b0010;
    localparam logic [3:0] c_alu_and   = 4'b0011;
    localparam logic [3:0] c_alu_or    = 4'b0100;
    localparam logic [3:0] c_alu_slt   = 4'b0101;

    localparam logic [CNT_W-1:0] c_one = 1;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] r_retired;

    // Next-state selection; opcode is only consulted where IR is stable.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_fetch:   w_next = mem_ready ? c_st_decode : c_st_fetch;
            c_st_decode: begin
                case (opcode)
                    c_op_lw, c_op_sw:                       w_next = c_st_memaddr;
                    c_op_rtype:                             w_next = c_st_exec;
                    c_op_beq, c_op_bne:                     w_next = c_st_branch;
                    c_op_j:                                 w_next = c_st_jump;
                    c_op_jal:                               w_next = c_st_jal;
                    c_op_addi, c_op_andi, c_op_ori, c_op_slti: w_next = c_st_iexec;
                    default:                                w_next = c_st_error;
                endcase
            end
            c_st_memaddr: w_next = (opcode == c_op_sw) ? c_st_memwr : c_st_memrd;
            c_st_memrd:   w_next = mem_ready ? c_st_memwb : c_st_memrd;
            c_st_memwr:   w_next = mem_ready ? c_st_fetch : c_st_memwr;
            c_st_exec:    w_next = c_st_rcomp;
            c_st_iexec:   w_next = c_st_icomp;
            c_st_memwb, c_st_rcomp, c_st_branch,
            c_st_jump, c_st_jal, c_st_icomp:
                          w_next = c_st_fetch;
            c_st_error:   w_next = c_st_error;
            default:      w_next = c_st_error;
        endcase
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_next;
        end
    end

    // Output decode of the current state; strobes are squashed during reset
    // while selects keep their FETCH values.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        MemtoReg    = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = c_alu_add;
        selectRa    = 1'b0;
        extendType  = 1'b0;
        bneSelect   = 1'b0;
        instr_done  = 1'b0;
        case (r_state)
            c_st_fetch: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            c_st_decode: begin
                ALUSrcB    = 2'b11;
                extendType = 1'b1;
            end
            c_st_memaddr: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                extendType = 1'b1;
            end
            c_st_memrd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            c_st_memwb: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b01;
                instr_done = 1'b1;
            end
            c_st_memwr: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            c_st_exec: begin
                ALUSrcA = 1'b1;
                ALUOp   = c_alu_funct;
            end
            c_st_rcomp: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            c_st_branch: begin
                ALUSrcA     = 1'b1;
                ALUOp       = c_alu_sub;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                bneSelect   = (opcode == c_op_bne);
                instr_done  = 1'b1;
            end
            c_st_jump: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            c_st_jal: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                RegWrite   = 1'b1;
                selectRa   = 1'b1;
                MemtoReg   = 2'b10;
                instr_done = 1'b1;
            end
            c_st_iexec: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (opcode)
                    c_op_andi: ALUOp = c_alu_and;
                    c_op_ori:  ALUOp = c_alu_or;
                    c_op_slti: ALUOp = c_alu_slt;
                    default:   ALUOp = c_alu_add;
                endcase
                extendType = (opcode == c_op_addi) || (opcode == c_op_slti);
            end
            c_st_icomp: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
            end
        endcase
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
            instr_done  = 1'b0;
        end
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (instr_done) begin
            r_retired <= r_retired + c_one;
        end
    end

    assign illegal = (r_state == c_st_error);
    assign retired = r_retired;
    assign state   = r_state;

endmodule
`default_nettype wire
